// File: rtl/spi_pkg.sv
// spi_pkg: types and helpers shared by the SPI master and the transaction arbiter.
// Contents: arbiter state enum, SPI mode enum, slave-select width helper,
// counter width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_GUARD
    } spi_arb_state_t;

    typedef enum logic [1:0] {
        SPI_MODE_0,
        SPI_MODE_1,
        SPI_MODE_2,
        SPI_MODE_3
    } spi_mode_t;

    // Slave index width; a single-slave build still carries a 1-bit index.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a down/up counter able to hold any of the three phase lengths.
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Ports:
//   i_req   [N]     request levels
//   i_ptr   [PTR_W] highest-priority index for this pick
//   o_gnt   [N]     one-hot winner (first set bit at or after i_ptr, wrapping)
//   o_valid         any request present
module rr_arbiter
    import spi_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic             o_valid
);

    logic [PTR_W-1:0] w_idx;
    logic             w_hit;

    always_comb begin
        o_gnt = '0;
        w_idx = '0;
        w_hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % N);
            if (!w_hit && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_hit        = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one SPI master engine with slave-select framing.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req / i_req_slave / i_req_data   per-requester request, slave index, tx word
//   o_gnt, o_done, o_err    one-hot grant, one-cycle completion pulse, out-of-range flag
//   o_rx_data               received word, valid from o_done until next capture
//   o_m_start, o_m_tx_data  engine start pulse and transmit word
//   i_m_done, i_m_rx_data   engine completion pulse and receive word
//   o_ss_n                  active-low slave selects
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int SLAVE_LINES  = 1,
    parameter  int DATA_W       = 8,
    parameter  int SETUP_CYCLES = 2,
    parameter  int HOLD_CYCLES  = 1,
    parameter  int GUARD_CYCLES = 2,
    localparam int SEL_W        = sel_w(SLAVE_LINES)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*SEL_W-1:0]  i_req_slave,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_done,
    output logic                      o_err,
    output logic [DATA_W-1:0]         o_rx_data,
    output logic                      o_m_start,
    output logic [DATA_W-1:0]         o_m_tx_data,
    input  logic                      i_m_done,
    input  logic [DATA_W-1:0]         i_m_rx_data,
    output logic [SLAVE_LINES-1:0]    o_ss_n
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_w(SETUP_CYCLES, HOLD_CYCLES, GUARD_CYCLES);

    spi_arb_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, w_lim;
    logic [PTR_W-1:0]       r_ptr, w_ptr_nxt, w_ptr_inc;
    logic [NUM_REQ-1:0]     r_gnt, w_gnt_nxt, r_done, w_done_nxt;
    logic                   r_err, w_err_nxt, r_start, w_start_nxt;
    logic [DATA_W-1:0]      r_rx_data, w_rx_nxt, r_tx_data, w_tx_nxt;
    logic [SLAVE_LINES-1:0] r_ss_n, w_ss_nxt, w_ss_sel;
    logic [NUM_REQ-1:0]     w_arb_gnt;
    logic                   w_arb_valid, w_cnt_last, w_counting, w_win_bad;
    logic [PTR_W-1:0]       w_win_idx;
    logic [SEL_W-1:0]       w_win_sel;
    logic [DATA_W-1:0]      w_win_data;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_valid (w_arb_valid)
    );

    // Encode the one-hot winner and pull out its slave index and tx word.
    always_comb begin
        w_win_idx  = '0;
        w_win_sel  = '0;
        w_win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_arb_gnt[k]) begin
                w_win_idx  = PTR_W'(k);
                w_win_sel  = i_req_slave[k*SEL_W +: SEL_W];
                w_win_data = i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_win_bad  = int'(w_win_sel) >= SLAVE_LINES;
    assign w_ss_sel   = ~(SLAVE_LINES'(1) << w_win_sel);
    assign w_ptr_inc  = (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;

    // One shared phase counter; its terminal value depends on the timed phase.
    assign w_lim      = (r_state == ST_SETUP) ? CNT_W'(SETUP_CYCLES - 1) :
                        (r_state == ST_HOLD)  ? CNT_W'(HOLD_CYCLES - 1)  :
                                                CNT_W'(GUARD_CYCLES - 1);
    assign w_cnt_last = r_cnt == w_lim;
    assign w_counting = (r_state == ST_SETUP) || (r_state == ST_HOLD) || (r_state == ST_GUARD);
    assign w_cnt_nxt  = (w_counting && w_state_nxt == r_state) ? r_cnt + 1'b1 : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_rx_nxt    = r_rx_data;
        w_start_nxt = 1'b0;
        w_tx_nxt    = r_tx_data;
        w_ss_nxt    = r_ss_n;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_ptr_nxt = w_ptr_inc;
                    w_tx_nxt  = w_win_data;
                    // A bad slave index completes at once with err and never touches the bus.
                    if (w_win_bad) begin
                        w_done_nxt  = w_arb_gnt;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_GUARD;
                    end else begin
                        w_gnt_nxt   = w_arb_gnt;
                        w_ss_nxt    = w_ss_sel;
                        w_state_nxt = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (w_cnt_last) begin
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (i_m_done) begin
                    w_rx_nxt    = i_m_rx_data;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_cnt_last) begin
                    w_ss_nxt    = '1;
                    w_done_nxt  = r_gnt;
                    w_gnt_nxt   = '0;
                    w_state_nxt = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (w_cnt_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rx_data <= '0;
            r_start   <= 1'b0;
            r_tx_data <= '0;
            r_ss_n    <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_rx_data <= w_rx_nxt;
            r_start   <= w_start_nxt;
            r_tx_data <= w_tx_nxt;
            r_ss_n    <= w_ss_nxt;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rx_data   = r_rx_data;
    assign o_m_start   = r_start;
    assign o_m_tx_data = r_tx_data;
    assign o_ss_n      = r_ss_n;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: scoreboard bench for spi_txn_arbiter with a behavioural SPI engine.
module tb_spi_txn_arbiter;

    localparam int NR    = 4;
    localparam int SL    = 3;
    localparam int DW    = 8;
    localparam int SW    = 2;
    localparam int SETUP = 2;
    localparam int HOLD  = 1;
    localparam int GUARD = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     i_req;
    logic [NR*SW-1:0]  i_req_slave;
    logic [NR*DW-1:0]  i_req_data;
    logic [NR-1:0]     o_gnt, o_done;
    logic              o_err, o_m_start, i_m_done;
    logic [DW-1:0]     o_rx_data, o_m_tx_data, i_m_rx_data;
    logic [SL-1:0]     o_ss_n;

    typedef struct {
        int         idx;
        int         slave;
        logic [7:0] tx;
        logic [7:0] rx;
        logic       err;
    } txn_t;

    txn_t       exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         req_cyc = 0;
    int         min_gap;
    bit         lat_chk = 0;
    bit         drop_early = 0;
    logic [1:0] slv [NR];
    logic [7:0] dat [NR];
    int         nd, ns;

    spi_txn_arbiter #(
        .NUM_REQ(NR), .SLAVE_LINES(SL), .DATA_W(DW),
        .SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD), .GUARD_CYCLES(GUARD)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_req_slave(i_req_slave),
        .i_req_data(i_req_data), .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err),
        .o_rx_data(o_rx_data), .o_m_start(o_m_start), .o_m_tx_data(o_m_tx_data),
        .i_m_done(i_m_done), .i_m_rx_data(i_m_rx_data), .o_ss_n(o_ss_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_cfg;
        for (int k = 0; k < NR; k++) begin
            i_req_slave[k*SW +: SW] = slv[k];
            i_req_data[k*DW +: DW]  = dat[k];
        end
    endtask

    task automatic push(input int idx, input logic [7:0] rx, input logic err);
        txn_t e;
        e.idx   = idx;
        e.slave = int'(slv[idx]);
        e.tx    = dat[idx];
        e.rx    = rx;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic quiet(input int n, output int n_done, output int n_start);
        n_done  = 0;
        n_start = 0;
        for (int i = 0; i < n; i++) begin
            tick;
            if (o_done != 0) n_done++;
            if (o_m_start) n_start++;
        end
    endtask

    // Runs the engine model and pops the scoreboard on each done until empty or out of budget.
    task automatic serve(input int budget);
        int            n, done_at, mdone_cyc, ss_fall, ss_rise;
        logic          prev_ss;
        logic [NR-1:0] prev_gnt;
        logic [SL-1:0] ss_exp;
        txn_t          e;
        bit            more;
        n         = 0;
        done_at   = -1;
        mdone_cyc = -100;
        ss_fall   = -100;
        ss_rise   = -1;
        prev_ss   = &o_ss_n;
        prev_gnt  = o_gnt;
        while (exp_q.size() > 0 && n < budget) begin
            tick;
            n++;
            i_m_done = 1'b0;
            if (cyc == done_at) begin
                i_m_done    = 1'b1;
                i_m_rx_data = exp_q[0].rx;
                mdone_cyc   = cyc;
            end
            if (!(&o_ss_n) && prev_ss) begin
                ss_fall = cyc;
                ss_exp  = ~(SL'(1) << exp_q[0].slave);
                chk("ss_sel", 32'(o_ss_n), 32'(ss_exp));
                chk("gnt", 32'(o_gnt), 32'(NR'(1) << exp_q[0].idx));
                if (ss_rise >= 0 && cyc - ss_rise < min_gap) min_gap = cyc - ss_rise;
            end
            if ((&o_ss_n) && !prev_ss) ss_rise = cyc;
            if (o_gnt != 0 && prev_gnt == 0) begin
                if (lat_chk) chk("gnt_lat", cyc - req_cyc, 1);
                lat_chk = 0;
                if (drop_early) i_req[exp_q[0].idx] = 1'b0;
            end
            if (o_m_start) begin
                if (exp_q[0].err) chk("start_on_err", 32'(o_m_start), 0);
                else begin
                    chk("setup_len", cyc - ss_fall, SETUP);
                    chk("tx", 32'(o_m_tx_data), 32'(exp_q[0].tx));
                    done_at = cyc + 7;
                end
            end
            if (o_done != 0) begin
                e = exp_q.pop_front();
                chk("done", 32'(o_done), 32'(NR'(1) << e.idx));
                chk("err", 32'(o_err), 32'(e.err));
                if (e.err) begin
                    chk("err_lat", 32'(cyc - req_cyc <= 2), 1);
                    chk("err_ss", 32'(o_ss_n), 32'(3'b111));
                end else begin
                    chk("rx", 32'(o_rx_data), 32'(e.rx));
                    chk("done_lat", cyc - mdone_cyc, HOLD + 1);
                end
                more = 0;
                foreach (exp_q[i]) if (exp_q[i].idx == e.idx) more = 1;
                if (!more) i_req[e.idx] = 1'b0;
            end
            prev_ss  = &o_ss_n;
            prev_gnt = o_gnt;
        end
        i_m_done = 1'b0;
        if (exp_q.size() != 0) begin
            chk("timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_req       = '0;
        i_m_done    = 1'b0;
        i_m_rx_data = '0;
        slv[0] = 2'd0; slv[1] = 2'd1; slv[2] = 2'd2; slv[3] = 2'd0;
        dat[0] = 8'hA5; dat[1] = 8'h5A; dat[2] = 8'hC3; dat[3] = 8'h81;
        apply_cfg;
        repeat (3) tick;
        chk("rst_gnt", 32'(o_gnt), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_rx", 32'(o_rx_data), 0);
        chk("rst_start", 32'(o_m_start), 0);
        chk("rst_tx", 32'(o_m_tx_data), 0);
        chk("rst_ss", 32'(o_ss_n), 32'(3'b111));
        rst_n = 1'b1;
        tick;

        // single request
        i_req = 4'b0001; req_cyc = cyc; lat_chk = 1;
        push(0, 8'h3C, 1'b0);
        serve(100);

        // stray m_done while idle
        quiet(4, nd, ns);
        i_m_done = 1'b1; i_m_rx_data = 8'hEE;
        tick;
        i_m_done = 1'b0;
        quiet(10, nd, ns);
        chk("stray_rx", 32'(o_rx_data), 32'h3C);
        chk("stray_done", nd, 0);
        chk("stray_start", ns, 0);
        chk("stray_gnt", 32'(o_gnt), 0);
        chk("stray_ss", 32'(o_ss_n), 32'(3'b111));

        // round-robin fairness from a fresh pointer
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        min_gap = 1000;
        i_req = 4'b1111;
        push(0, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(2, 8'h33, 1'b0);
        push(3, 8'h44, 1'b0);
        push(0, 8'h55, 1'b0);
        serve(400);
        chk("ss_gap", 32'(min_gap >= GUARD + 1), 1);

        // request withdrawn right after grant
        quiet(5, nd, ns);
        i_req = 4'b0010; req_cyc = cyc; lat_chk = 1; drop_early = 1;
        push(1, 8'h66, 1'b0);
        serve(100);
        drop_early = 0;
        quiet(20, nd, ns);
        chk("withdraw_once", nd, 0);

        // out-of-range slave index
        quiet(5, nd, ns);
        slv[2] = 2'd3;
        apply_cfg;
        i_req = 4'b0100; req_cyc = cyc;
        push(2, 8'h00, 1'b1);
        serve(20);
        quiet(10, nd, ns);
        chk("oor_no_start", ns, 0);
        chk("oor_no_redone", nd, 0);
        chk("oor_ss", 32'(o_ss_n), 32'(3'b111));

        // reset while waiting on the engine
        quiet(5, nd, ns);
        slv[3] = 2'd1;
        apply_cfg;
        i_req = 4'b1000;
        for (int i = 0; i < 20 && !o_m_start; i++) tick;
        chk("xfer_start", 32'(o_m_start), 1);
        chk("xfer_ss", 32'(o_ss_n), 32'(3'b101));
        repeat (3) tick;
        rst_n = 1'b0;
        #1;
        chk("arst_ss", 32'(o_ss_n), 32'(3'b111));
        chk("arst_gnt", 32'(o_gnt), 0);
        i_req = '0;
        tick;
        rst_n = 1'b1;
        tick;
        i_m_done = 1'b1; i_m_rx_data = 8'h99;
        tick;
        i_m_done = 1'b0;
        quiet(20, nd, ns);
        chk("arst_no_done", nd, 0);
        chk("arst_rx", 32'(o_rx_data), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
